rr_grant_scheduler: RTL

//  Round-robin scheduler that shares one resource (e.g. the AES round datapath) among 2**BITS requesters.

---
 rtl/rr_grant_scheduler.sv | 110 +++++++++++
 1 files changed

// File: rtl/rr_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_scheduler
// Description : Round-robin owner scheduler for one shared resource; the grant
//               is held until done or until the hold limit forces a release.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_scheduler #(
    parameter int BITS     = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [(1<<BITS)-1:0]   req,
    input  logic                   done,
    output logic [(1<<BITS)-1:0]   gnt,
    output logic [BITS-1:0]        gnt_idx,
    output logic                   gnt_valid,
    output logic                   timeout
);

    localparam int c_N_REQ = 1 << BITS;
    localparam int c_CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = (MAX_HOLD > 0) ? c_CNT_W'(MAX_HOLD - 1) : '0;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = '1;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    generate
        if (BITS < 1) begin : g_bits_check
            $error("rr_grant_scheduler: BITS must be at least 1");
        end
    endgenerate

    logic [0:0]         r_state;
    logic [BITS-1:0]    r_ptr;
    logic [c_CNT_W-1:0] r_hold_cnt;
    logic [c_N_REQ-1:0] r_gnt;
    logic [BITS-1:0]    r_gnt_idx;
    logic               r_timeout;

    logic [BITS-1:0]    w_win_idx;
    logic               w_expire;

    // Scan from the highest offset down so the request closest to ptr wins.
    function automatic logic [BITS-1:0] f_pick(input logic [c_N_REQ-1:0] r,
                                               input logic [BITS-1:0]    p);
        logic [BITS-1:0] cand;
        logic [BITS-1:0] win;
        win = p;
        for (int i = c_N_REQ - 1; i >= 0; i--) begin
            cand = p + BITS'(i);
            if (r[cand]) begin
                win = cand;
            end
        end
        return win;
    endfunction

    always_comb begin
        w_win_idx = f_pick(req, r_ptr);
        w_expire  = (MAX_HOLD > 0) && (r_hold_cnt == c_HOLD_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (|req) begin
                        r_state    <= c_BUSY;
                        r_gnt_idx  <= w_win_idx;
                        r_gnt      <= c_N_REQ'(1) << w_win_idx;
                        r_hold_cnt <= '0;
                    end
                end
                c_BUSY: begin
                    if (r_hold_cnt != c_CNT_MAX) begin
                        r_hold_cnt <= r_hold_cnt + c_CNT_W'(1);
                    end
                    // done wins over a coincident expiry, so no timeout pulse then.
                    if (done || w_expire) begin
                        r_state   <= c_IDLE;
                        r_gnt     <= '0;
                        r_ptr     <= r_gnt_idx + BITS'(1);
                        r_timeout <= !done;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = (r_state == c_BUSY);
    assign timeout   = r_timeout;

endmodule
`default_nettype wire
